// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load unit.
//   - load type codes presented on load_type (LB..LW; other codes behave as LW)
//   - data_size codes driven toward the SRAM-like port
//   - FSM state encoding
//   - helpers that map a load type to its access size and detect misalignment
package load_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LBU = 3'b001;
    localparam logic [2:0] LT_LH  = 3'b010;
    localparam logic [2:0] LT_LHU = 3'b011;
    localparam logic [2:0] LT_LW  = 3'b100;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } load_state_e;

    // Access size for a load type; unknown codes are treated as word loads.
    function automatic logic [1:0] size_of(input logic [2:0] t);
        case (t)
            LT_LB, LT_LBU: return SZ_BYTE;
            LT_LH, LT_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    // Natural-alignment check on the low address bits.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        case (t)
            LT_LB, LT_LBU: return 1'b0;
            LT_LH, LT_LHU: return a[0];
            default:       return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational extraction of the addressed byte/halfword from a
// 32-bit read word, followed by sign or zero extension. Also used by the
// uncached/debug read path.
// Ports:
//   rdata_i   [31:0] raw read word
//   addr_lo_i [1:0]  byte offset of the load within the word
//   type_i    [2:0]  load type code (load_pkg LT_*)
//   result_o  [31:0] aligned, extended load data
module load_align
    import load_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  type_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        case (type_i)
            LT_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  result_o = {24'h000000, byte_v};
            LT_LH:   result_o = {{16{half_v[15]}}, half_v};
            LT_LHU:  result_o = {16'h0000, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: MEM-stage load controller. Issues one SRAM-like read per load,
// stalls the pipeline until the data returns, aligns/extends it and holds the
// result until the MEM->WB transfer.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load_en, load_type,      load instruction presented by the MEM stage
//   load_addr
//   mem_advance              MEM->WB transfer, consumes the result
//   flush                    exception/eret flush of the MEM stage
//   data_req/wr/size/addr    SRAM-like request channel (data_wr tied 0)
//   data_addr_ok             request accepted
//   data_data_ok, data_rdata read response
//   load_stall               stall request to the hazard unit
//   load_result              aligned load data (valid in DONE)
//   load_adel                address error on load
//   dbg_state                current FSM state for observation
//
// Handshake: a request is transferred on a cycle where data_req && data_addr_ok;
// data_addr and data_size are held stable while data_req is high. Exactly one
// data_data_ok is expected per accepted request, no earlier than the cycle
// after acceptance; a data_data_ok seen outside WAIT/DRAIN is ignored.
module load_unit
    import load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [2:0]  load_type,
    input  logic [31:0] load_addr,
    input  logic        mem_advance,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        load_stall,
    output logic [31:0] load_result,
    output logic        load_adel,
    output load_state_e dbg_state
);

    load_state_e state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] result_q, result_d;
    logic [31:0] aligned;
    logic        misaligned;

    load_align u_align (
        .rdata_i   (data_rdata),
        .addr_lo_i (addr_q[1:0]),
        .type_i    (type_q),
        .result_o  (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            type_q   <= LT_LB;
            addr_q   <= 32'h0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        result_d   = result_q;
        misaligned = is_misaligned(load_type, load_addr[1:0]);
        load_adel  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_adel = load_en && misaligned;
                if (load_en && !misaligned && !flush) begin
                    type_d  = load_type;
                    addr_d  = load_addr;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A flush in the accepting cycle still leaves a response in
                // flight, so that case must drain rather than go idle.
                if (data_addr_ok)
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                else if (flush)
                    state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        result_d = aligned;
                        state_d  = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (mem_advance || flush)
                    state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_req    = (state_q == ST_REQ);
    assign data_wr     = 1'b0;
    assign data_size   = size_of(type_q);
    assign data_addr   = addr_q;
    assign load_result = result_q;
    assign load_stall  = load_en && !load_adel && (state_q != ST_DONE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [2:0]  load_type;
    logic [31:0] load_addr;
    logic        mem_advance;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        load_stall;
    logic [31:0] load_result;
    logic        load_adel;
    load_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;

    typedef struct {
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_res;
        logic        exp_adel;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t vecs[15];

    load_unit dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_type    (load_type),
        .load_addr    (load_addr),
        .mem_advance  (mem_advance),
        .flush        (flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .load_stall   (load_stall),
        .load_result  (load_result),
        .load_adel    (load_adel),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // driver: one load from the table, addr_ok in c1, data_ok in c2
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        load_en   = 1'b1;
        load_type = v.ty;
        load_addr = v.addr;
        #1;
        chk($sformatf("v%0d adel", i), {31'b0, load_adel}, {31'b0, v.exp_adel});
        if (v.exp_adel) begin
            chk($sformatf("v%0d adel_stall", i), {31'b0, load_stall}, 32'd0);
            for (int c = 0; c < 2; c++) begin
                step();
                chk($sformatf("v%0d adel_req", i), {31'b0, data_req}, 32'd0);
                chk($sformatf("v%0d adel_state", i), {29'b0, dbg_state}, {29'b0, ST_IDLE});
            end
            load_en = 1'b0;
            step();
        end else begin
            chk($sformatf("v%0d c0_stall", i), {31'b0, load_stall}, 32'd1);
            chk($sformatf("v%0d c0_req", i), {31'b0, data_req}, 32'd0);
            step();
            data_addr_ok = 1'b1;
            #1;
            chk($sformatf("v%0d c1_state", i), {29'b0, dbg_state}, {29'b0, ST_REQ});
            chk($sformatf("v%0d c1_req", i), {31'b0, data_req}, 32'd1);
            chk($sformatf("v%0d c1_addr", i), data_addr, v.addr);
            chk($sformatf("v%0d c1_size", i), {30'b0, data_size}, {30'b0, v.exp_size});
            chk($sformatf("v%0d c1_wr", i), {31'b0, data_wr}, 32'd0);
            chk($sformatf("v%0d c1_stall", i), {31'b0, load_stall}, 32'd1);
            step();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
            data_rdata   = v.rdata;
            #1;
            chk($sformatf("v%0d c2_state", i), {29'b0, dbg_state}, {29'b0, ST_WAIT});
            chk($sformatf("v%0d c2_req", i), {31'b0, data_req}, 32'd0);
            chk($sformatf("v%0d c2_stall", i), {31'b0, load_stall}, 32'd1);
            step();
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
            #1;
            chk($sformatf("v%0d c3_state", i), {29'b0, dbg_state}, {29'b0, ST_DONE});
            chk($sformatf("v%0d c3_stall", i), {31'b0, load_stall}, 32'd0);
            chk($sformatf("v%0d c3_result", i), load_result, v.exp_res);
            step();
            chk($sformatf("v%0d c4_hold", i), load_result, v.exp_res);
            chk($sformatf("v%0d c4_state", i), {29'b0, dbg_state}, {29'b0, ST_DONE});
            mem_advance = 1'b1;
            step();
            mem_advance = 1'b0;
            load_en     = 1'b0;
            #1;
            chk($sformatf("v%0d c5_state", i), {29'b0, dbg_state}, {29'b0, ST_IDLE});
            last_result = v.exp_res;
        end
    endtask

    initial begin
        // stimulus table: {type, addr, rdata, expected result, expected adel, expected size}
        vecs[0]  = '{LT_LW,  32'h0000_1000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, SZ_WORD};
        vecs[1]  = '{LT_LB,  32'h0000_2003, 32'h80FF1234, 32'hFFFFFF80, 1'b0, SZ_BYTE};
        vecs[2]  = '{LT_LBU, 32'h0000_2003, 32'h80FF1234, 32'h00000080, 1'b0, SZ_BYTE};
        vecs[3]  = '{LT_LH,  32'h0000_2002, 32'h80011234, 32'hFFFF8001, 1'b0, SZ_HALF};
        vecs[4]  = '{LT_LHU, 32'h0000_2002, 32'h80011234, 32'h00008001, 1'b0, SZ_HALF};
        vecs[5]  = '{LT_LB,  32'h0000_2000, 32'h80FF1234, 32'h00000034, 1'b0, SZ_BYTE};
        vecs[6]  = '{LT_LB,  32'h0000_2001, 32'h80FF1234, 32'h00000012, 1'b0, SZ_BYTE};
        vecs[7]  = '{LT_LB,  32'h0000_2002, 32'h80FF1234, 32'hFFFFFFFF, 1'b0, SZ_BYTE};
        vecs[8]  = '{LT_LH,  32'h0000_2000, 32'h0000F00D, 32'hFFFFF00D, 1'b0, SZ_HALF};
        vecs[9]  = '{3'b111, 32'h0000_3004, 32'h12345678, 32'h12345678, 1'b0, SZ_WORD};
        vecs[10] = '{LT_LW,  32'h0000_1002, 32'h0,        32'h0,        1'b1, SZ_WORD};
        vecs[11] = '{LT_LH,  32'h0000_1001, 32'h0,        32'h0,        1'b1, SZ_HALF};
        vecs[12] = '{LT_LHU, 32'h0000_1003, 32'h0,        32'h0,        1'b1, SZ_HALF};
        vecs[13] = '{LT_LBU, 32'h0000_1001, 32'hAABBCCDD, 32'h000000CC, 1'b0, SZ_BYTE};
        vecs[14] = '{3'b101, 32'h0000_1001, 32'h0,        32'h0,        1'b1, SZ_WORD};

        rst = 1'b1;
        load_en = 1'b0; load_type = 3'b000; load_addr = 32'h0;
        mem_advance = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        last_result = 32'h0;
        step();
        step();
        chk("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        chk("rst_req", {31'b0, data_req}, 32'd0);
        chk("rst_wr", {31'b0, data_wr}, 32'd0);
        chk("rst_size", {30'b0, data_size}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_result", load_result, 32'd0);
        chk("rst_stall", {31'b0, load_stall}, 32'd0);
        chk("rst_adel", {31'b0, load_adel}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) run_vec(i);

        // flush in WAIT, data returns 3 cycles later, new LW waits behind the drain
        load_en = 1'b1; load_type = LT_LW; load_addr = 32'h0000_4000;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        load_en = 1'b0;
        #1;
        chk("fl_wait_state", {29'b0, dbg_state}, {29'b0, ST_WAIT});
        step();
        flush = 1'b0;
        load_en = 1'b1; load_type = LT_LW; load_addr = 32'h0000_5000;
        #1;
        chk("fl_drain_state", {29'b0, dbg_state}, {29'b0, ST_DRAIN});
        chk("fl_drain_stall", {31'b0, load_stall}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("fl_drain_noreq", {31'b0, data_req}, 32'd0);
            chk("fl_drain_hold", {29'b0, dbg_state}, {29'b0, ST_DRAIN});
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'h11111111;
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk("fl_idle_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        chk("fl_result_kept", load_result, last_result);
        chk("fl_idle_stall", {31'b0, load_stall}, 32'd1);
        chk("fl_idle_noreq", {31'b0, data_req}, 32'd0);
        step();
        data_addr_ok = 1'b1;
        #1;
        chk("fl_new_req", {31'b0, data_req}, 32'd1);
        chk("fl_new_addr", data_addr, 32'h0000_5000);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h22222222;
        step();
        data_data_ok = 1'b0;
        #1;
        chk("fl_new_done", {29'b0, dbg_state}, {29'b0, ST_DONE});
        chk("fl_new_result", load_result, 32'h22222222);
        // flush while in DONE releases the unit
        flush = 1'b1;
        load_en = 1'b0;
        step();
        flush = 1'b0;
        #1;
        chk("fl_done_idle", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        last_result = 32'h22222222;

        // addr_ok held off for 5 cycles; stray data_ok in REQ and with addr_ok ignored
        load_en = 1'b1; load_type = LT_LHU; load_addr = 32'h0000_6002;
        step();
        for (int c = 0; c < 5; c++) begin
            data_data_ok = (c == 2);
            data_rdata   = 32'h5555AAAA;
            #1;
            chk("st_req", {31'b0, data_req}, 32'd1);
            chk("st_addr", data_addr, 32'h0000_6002);
            chk("st_size", {30'b0, data_size}, {30'b0, SZ_HALF});
            chk("st_stall", {31'b0, load_stall}, 32'd1);
            step();
        end
        data_data_ok = 1'b1;
        data_addr_ok = 1'b1;
        #1;
        chk("st_req_last", {31'b0, data_req}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        chk("st_wait", {29'b0, dbg_state}, {29'b0, ST_WAIT});
        step();
        chk("st_wait_hold", {29'b0, dbg_state}, {29'b0, ST_WAIT});
        chk("st_wait_result", load_result, last_result);
        data_data_ok = 1'b1;
        data_rdata   = 32'hABCD0000;
        step();
        data_data_ok = 1'b0;
        #1;
        chk("st_done", {29'b0, dbg_state}, {29'b0, ST_DONE});
        chk("st_result", load_result, 32'h0000ABCD);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0;
        load_en = 1'b0;
        step();

        // reset pulsed in WAIT
        load_en = 1'b1; load_type = LT_LW; load_addr = 32'h0000_7000;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("rw_wait", {29'b0, dbg_state}, {29'b0, ST_WAIT});
        rst = 1'b1;
        #1;
        chk("rw_req", {31'b0, data_req}, 32'd0);
        chk("rw_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        chk("rw_result", load_result, 32'd0);
        chk("rw_addr", data_addr, 32'd0);
        load_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rw_after", {29'b0, dbg_state}, {29'b0, ST_IDLE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
